// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage access controller: direct/indirect loads and stores with
// byte-lane steering, stalling the pipeline until the data-memory port responds.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        read,
  input  logic        write,
  input  logic        indirect,
  input  logic [1:0]  mem_byte_sig,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [15:0] rdata
);

  typedef enum logic [1:0] {IDLE, IND, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        ind;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  state_t      state, nxt;
  req_t        req_q;
  logic [15:0] ptr_q;
  logic [15:0] rdata_q;
  logic        accept;
  logic        byte_acc;
  logic [15:0] ea;
  logic [15:0] lane_data;

  assign accept    = (state == IDLE) & req_valid & (read | write);
  assign ea        = req_q.ind ? ptr_q : req_q.addr;
  // Indirect forces word size on both phases.
  assign byte_acc  = (req_q.size == 2'b01) & ~req_q.ind;
  assign lane_data = byte_acc ? {8'h00, ea[0] ? mem_rdata[15:8] : mem_rdata[7:0]}
                              : mem_rdata;
  assign rdata     = rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      req_q   <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        // Read wins when both are set; the write is dropped here.
        req_q <= '{rd: read, wr: write & ~read, ind: indirect,
                   size: mem_byte_sig, addr: addr, wdata: wdata};
      end
      if (state == IND && mem_resp)
        ptr_q <= mem_rdata;
      if (state == ACCESS && mem_resp && req_q.rd)
        rdata_q <= lane_data;
    end
  end

  always_comb begin
    nxt             = state;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    stall           = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) nxt = indirect ? IND : ACCESS;
      end
      IND: begin
        stall           = 1'b1;
        mem_read        = 1'b1;
        mem_address     = {req_q.addr[15:1], 1'b0};
        mem_byte_enable = 2'b11;
        if (mem_resp) nxt = ACCESS;
      end
      ACCESS: begin
        stall     = 1'b1;
        mem_read  = req_q.rd;
        mem_write = req_q.wr;
        if (byte_acc) begin
          mem_address     = ea;
          mem_byte_enable = ea[0] ? 2'b10 : 2'b01;
          mem_wdata       = {req_q.wdata[7:0], req_q.wdata[7:0]};
        end else begin
          mem_address     = {ea[15:1], 1'b0};
          mem_byte_enable = 2'b11;
          mem_wdata       = req_q.wdata;
        end
        if (mem_resp) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: the bench plays the data memory with
// programmable wait states and predicts every bus cycle from the access rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, read, write, indirect;
  logic [1:0]  mem_byte_sig;
  logic [15:0] addr, wdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        stall, done;
  logic [15:0] rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .read(read),
    .write(write), .indirect(indirect), .mem_byte_sig(mem_byte_sig),
    .addr(addr), .wdata(wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .stall(stall), .done(done), .rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_phase(input string tag, input int waits, input logic er, input logic ew,
                           input logic [15:0] ea, input logic [15:0] ewd, input logic [1:0] ebe,
                           input logic [15:0] final_data);
    for (int w = 0; w <= waits; w++) begin
      #1;
      chk({tag, "_rd"}, mem_read, er);
      chk({tag, "_wr"}, mem_write, ew);
      chk({tag, "_addr"}, mem_address, ea);
      chk({tag, "_wdata"}, mem_wdata, ewd);
      chk({tag, "_be"}, mem_byte_enable, ebe);
      chk({tag, "_stall"}, stall, 1'b1);
      chk({tag, "_done"}, done, 1'b0);
      mem_resp  = (w == waits);
      mem_rdata = (w == waits) ? final_data : 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      mem_resp  = 1'b0;
    end
  endtask

  // One complete request; ptr is the pointer returned by the first indirect read,
  // data is what the final access read returns.
  task automatic txn(input logic rd, input logic wr, input logic ind, input logic [1:0] mbs,
                     input logic [15:0] a, input logic [15:0] wd, input int w0, input int w1,
                     input logic [15:0] ptr, input logic [15:0] data);
    logic [15:0] ea, exp_addr, exp_wd;
    logic [1:0]  exp_be;
    logic        byt;
    ea       = ind ? ptr : a;
    byt      = (mbs == 2'b01) && !ind;
    exp_addr = byt ? ea : {ea[15:1], 1'b0};
    exp_be   = byt ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
    exp_wd   = byt ? {wd[7:0], wd[7:0]} : wd;

    @(negedge clk);
    req_valid = 1'b1; read = rd; write = wr; indirect = ind;
    mem_byte_sig = mbs; addr = a; wdata = wd;
    #1;
    chk("accept_stall", stall, 1'b1);
    chk("accept_rd", mem_read, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid = $urandom_range(0, 1); read = 1'($urandom); write = 1'($urandom);
    indirect = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
    mem_byte_sig = 2'($urandom);
    if (ind) bus_phase("ind", w0, 1'b1, 1'b0, {a[15:1], 1'b0}, 16'h0, 2'b11, ptr);
    bus_phase("acc", w1, rd, wr & ~rd, exp_addr, exp_wd, exp_be, data);
    #1;
    chk("done_pulse", done, 1'b1);
    chk("done_stall", stall, 1'b0);
    chk("done_strobes", {mem_read, mem_write}, 2'b00);
    chk("done_addr", mem_address, 16'h0);
    if (rd) exp_rdata = byt ? {8'h00, ea[0] ? data[15:8] : data[7:0]} : data;
    chk("rdata", rdata, exp_rdata);
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; read = 1'b0; write = 1'b0; indirect = 1'b0;
    mem_byte_sig = 2'b00; addr = '0; wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_bus", {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    txn(1, 0, 0, 2'b00, 16'h1235, 16'h0, 0, 2, 16'h0, 16'hBEEF);   // word load, 2 waits
    txn(0, 1, 0, 2'b01, 16'h2001, 16'h00A5, 0, 0, 16'h0, 16'h0);   // byte store high lane
    txn(1, 0, 0, 2'b01, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h7F80);   // byte load low lane
    txn(1, 0, 0, 2'b01, 16'h3001, 16'h0, 0, 0, 16'h0, 16'h7F80);   // byte load high lane
    txn(1, 0, 1, 2'b00, 16'h4000, 16'h0, 0, 0, 16'h5002, 16'h1111); // LDI
    txn(0, 1, 1, 2'b01, 16'h4000, 16'h9A3C, 0, 0, 16'h6001, 16'h0); // STI ignores byte size
    txn(1, 1, 0, 2'b10, 16'h0F0F, 16'h5555, 0, 1, 16'h0, 16'hC3C3); // read beats write

    // No-op request never stalls or leaves IDLE
    @(negedge clk);
    req_valid = 1'b1; read = 1'b0; write = 1'b0;
    #1 chk("noop_stall", stall, 1'b0);
    @(negedge clk);
    #1;
    chk("noop_stall2", stall, 1'b0);
    chk("noop_bus", {mem_read, mem_write, done}, 3'b000);
    req_valid = 1'b0;

    // Reset while the second phase of an LDI is outstanding
    @(negedge clk);
    req_valid = 1'b1; read = 1'b1; write = 1'b0; indirect = 1'b1;
    mem_byte_sig = 2'b00; addr = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h5002;
    @(posedge clk);
    @(negedge clk);
    mem_resp = 1'b0;
    #1 chk("pre_rst_rd", mem_read, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_rd", mem_read, 1'b0);
    chk("mid_rst_rdata", rdata, 16'h0);
    exp_rdata = 16'h0;
    @(negedge clk);
    reset_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk("stale_resp_done", done, 1'b0);
    chk("stale_resp_rdata", rdata, 16'h0);
    chk("stale_resp_stall", stall, 1'b0);
    txn(1, 0, 0, 2'b11, 16'h0ACE, 16'h0, 0, 1, 16'h0, 16'h2468);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic rd, wr;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      txn(rd, wr, 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller for the LC-3b pipeline. Accepts the MEM-stage control bundle produced by instruction decode (`read`, `write`, `indirect`, `mem_byte_sig`) with the ALU-computed address and store data. Executes the access against the data-memory port, including the two-phase indirect sequence for LDI/STI and byte-lane steering for LDB/STB. Stalls the pipeline until the access completes.

## Interface

Parameters:
- none (16-bit datapath, word = 2 bytes, fixed by the LC-3b ISA)

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  MEM-stage instruction valid
- `read`  in  1  load request
- `write`  in  1  store request
- `indirect`  in  1  first access fetches a pointer; the second access uses that pointer
- `mem_byte_sig`  in  2  access size: 01 = byte; 00, 10, 11 = word
- `addr`  in  16  effective address from the ALU
- `wdata`  in  16  store data (SR)
- `mem_read`  out  1  data-memory read strobe
- `mem_write`  out  1  data-memory write strobe
- `mem_address`  out  16  data-memory address
- `mem_wdata`  out  16  data-memory write data
- `mem_byte_enable`  out  2  lane enables; bit1 = high byte
- `mem_resp`  in  1  memory completion, one cycle per strobe
- `mem_rdata`  in  16  memory read data, valid with `mem_resp`
- `stall`  out  1  hold all pipeline registers upstream of and including MEM
- `done`  out  1  one-cycle pulse when the access has completed
- `rdata`  out  16  load result (registered) for writeback

## Operation

- States: IDLE, IND, ACCESS, DONE.
- IDLE:
  - When `req_valid & (read | write)`, latch `read`, `write`, `indirect`, `mem_byte_sig`, `addr`, and `wdata`.
  - Go to IND if `indirect`; otherwise go to ACCESS.
  - If `read` and `write` are both high, read wins and write is dropped.
- IND:
  - Drive `mem_read=1`, `mem_address={addr[15:1],0}`, `mem_byte_enable=11`.
  - On `mem_resp`, latch the pointer from `mem_rdata` and go to ACCESS.
- ACCESS:
  - Effective address (EA) is the pointer if indirect, else the latched `addr`.
  - Word access: `mem_address={EA[15:1],0}`, `mem_byte_enable=11`, `mem_wdata=wdata`.
  - Byte access: `mem_address=EA` and `mem_byte_enable = EA[0] ? 10 : 01`.
    - Store data is replicated: `mem_wdata={wdata[7:0],wdata[7:0]}`.
    - Load data is zero-extended from the selected lane: `{8'h00, EA[0] ? mem_rdata[15:8] : mem_rdata[7:0]}`.
  - Indirect ignores `mem_byte_sig`; both phases are word accesses.
  - Strobe is `mem_read` for loads and `mem_write` for stores.
  - On `mem_resp`: for a load, register the result into `rdata`; then go to DONE.
- DONE: `done=1`, `stall=0`, then go to IDLE unconditionally. The request inputs are ignored in DONE.
- `stall = (IDLE & req_valid & (read|write)) | IND | ACCESS`.
- `rdata` holds its value until the next load completes. Stores do not modify it.
- Outside IND and ACCESS: `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, and `mem_byte_enable` are all 0.

## Timing

- Reset (async, any state):
  - State goes to IDLE.
  - `rdata`, the pointer, and all latched request fields become 0.
  - All outputs are 0 and `stall` is 0, unless `req_valid & (read|write)` is present in IDLE, in which case `stall` is combinationally high.
  - An in-flight memory access is abandoned; any later `mem_resp` is ignored in IDLE.
- Strobes and address are stable from entry into IND or ACCESS until the cycle `mem_resp` is seen. They deassert the cycle after.
- Latency with zero-wait memory (`mem_resp` in the same cycle as the strobe):
  - Direct access: accept at C0, ACCESS at C1, `done` at C2. `stall` is high in C0 and C1.
  - Indirect access: C0 accept, C1 IND, C2 ACCESS, C3 `done`.
- Each memory wait cycle adds one cycle to the phase it occurs in.
- A request present at DONE+1 (the next instruction) is accepted in that IDLE cycle. This gives no back-to-back bubble beyond the DONE cycle.
- `req_valid` with `read=write=0` never stalls and never leaves IDLE.

## Test plan

- Word load: `addr=0x1235`, `mem_rdata=0xBEEF` with a 2-cycle wait.
  - Expect `mem_address=0x1234`, `mem_byte_enable=11`, `mem_read` high for 3 cycles.
  - Expect `rdata=0xBEEF` and a `done` pulse; `stall` is high for 4 cycles.
- Byte store: `addr=0x2001`, `wdata=0x00A5`, zero-wait memory.
  - Expect `mem_address=0x2001`, `mem_byte_enable=10`, `mem_wdata=0xA5A5`.
  - Expect `done` at C2 and `rdata` unchanged.
- Byte load, low and high lane: `mem_rdata=0x7F80`.
  - `addr=0x3000` gives `rdata=0x0080`.
  - `addr=0x3001` gives `rdata=0x007F`.
- LDI: `addr=0x4000`, pointer read returns `0x5002`, second read returns `0x1111`.
  - Expect two `mem_read` phases at 0x4000 then 0x5002, `rdata=0x1111`, `done` at C3.
- STI: `addr=0x4000`, pointer `0x6001`, `mem_byte_sig=01`.
  - Expect the second phase to be a `mem_write` at 0x6000 with enable 11 and `mem_wdata=wdata`.
- Reset during ACCESS of an LDI:
  - Expect `stall`, `mem_read`, and `rdata` at 0 immediately.
  - A subsequent `mem_resp` is ignored.
  - A fresh word load completes normally.
